// File: rtl/find_pivot_col_multi.sv
// find_pivot_col_multi
//   Streams the simplex objective row (IEEE-754 single, LANES values per beat,
//   lane 0 = lowest column of the beat) and selects the entering column.
//   Dantzig mode (mode=0) picks the most negative qualifying value, with ties
//   going to the lowest column. Bland mode (mode=1) picks the first qualifying
//   value. A value qualifies only if it is negative, is not NaN, and its
//   magnitude is strictly greater than eps. The compare is done on raw bits.
//
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   start              one-cycle pulse; latches num_cols/mode/eps (IDLE only)
//   num_cols           number of valid columns in the row
//   mode               0 = Dantzig, 1 = Bland
//   eps                non-negative fp32 tolerance
//   s_axis_*           objective-row beat stream
//   busy               scan in progress
//   done               one-cycle result pulse
//   terminate / cont   no qualifying column / pivot found (held until next start)
//   pivot_col/pivot_val selected column index and its raw value bits
module find_pivot_col_multi #(
  parameter int LANES = 4,
  parameter int COLW  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [COLW-1:0]       num_cols,
  input  logic                  mode,
  input  logic [31:0]           eps,
  input  logic [32*LANES-1:0]   s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  busy,
  output logic                  done,
  output logic                  terminate,
  output logic                  cont,
  output logic [COLW-1:0]       pivot_col,
  output logic [31:0]           pivot_val
);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t            state, state_next;
  logic [COLW-1:0]   num_cols_q;
  logic              mode_q;
  logic [30:0]       eps_q;
  logic [COLW-1:0]   col_base;
  logic              best_valid;
  logic [COLW-1:0]   best_col;
  logic [31:0]       best_val;

  logic              beat;
  logic              last_beat;
  logic [LANES-1:0]  qual;
  logic              win_found;
  logic [COLW-1:0]   win_col;
  logic [31:0]       win_val;
  logic              take;
  logic              nb_valid;
  logic [COLW-1:0]   nb_col;
  logic [31:0]       nb_val;

  // eps is non-negative by contract, so its sign bit carries no information.
  logic eps_sign_unused;
  assign eps_sign_unused = eps[31];

  assign beat      = s_axis_tvalid & s_axis_tready;
  assign last_beat = ({1'b0, col_base} + (COLW+1)'(LANES)) >= {1'b0, num_cols_q};

  // Per-lane qualification, including masking of lanes beyond num_cols.
  always_comb begin
    qual = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      qual[i] = ((col_base + COLW'(i)) < num_cols_q)
              & s_axis_tdata[32*i+31]
              & ~((s_axis_tdata[32*i+23 +: 8] == 8'hFF) && (s_axis_tdata[32*i +: 23] != '0))
              & (s_axis_tdata[32*i +: 31] > eps_q);
    end
  end

  // Beat winner: Bland keeps the first qualifying lane; Dantzig replaces only
  // on a strictly larger magnitude, so equal magnitudes stay at the lower lane.
  always_comb begin
    win_found = 1'b0;
    win_col   = '0;
    win_val   = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (qual[i] && (!win_found ||
          (!mode_q && (s_axis_tdata[32*i +: 31] > win_val[30:0])))) begin
        win_found = 1'b1;
        win_col   = col_base + COLW'(i);
        win_val   = s_axis_tdata[32*i +: 32];
      end
    end
  end

  assign take     = win_found & (~best_valid | (~mode_q & (win_val[30:0] > best_val[30:0])));
  assign nb_valid = best_valid | win_found;
  assign nb_col   = take ? win_col : best_col;
  assign nb_val   = take ? win_val : best_val;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next    = state;
    s_axis_tready = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = (num_cols == '0) ? REPORT : SCAN;
      end
      SCAN: begin
        s_axis_tready = 1'b1;
        busy          = 1'b1;
        if (beat && last_beat) state_next = REPORT;
      end
      REPORT: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result outputs are loaded on the edge that enters REPORT (from the merged
  // best including the final beat), so they are already valid while done=1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      num_cols_q <= '0;
      mode_q     <= 1'b0;
      eps_q      <= '0;
      col_base   <= '0;
      best_valid <= 1'b0;
      best_col   <= '0;
      best_val   <= '0;
      terminate  <= 1'b0;
      cont       <= 1'b0;
      pivot_col  <= '0;
      pivot_val  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            num_cols_q <= num_cols;
            mode_q     <= mode;
            eps_q      <= eps[30:0];
            col_base   <= '0;
            best_valid <= 1'b0;
            best_col   <= '0;
            best_val   <= '0;
            cont       <= 1'b0;
            terminate  <= (num_cols == '0);
            if (num_cols == '0) begin
              pivot_col <= '0;
              pivot_val <= '0;
            end
          end
        end
        SCAN: begin
          if (beat) begin
            col_base   <= col_base + COLW'(LANES);
            best_valid <= nb_valid;
            best_col   <= nb_col;
            best_val   <= nb_val;
            if (last_beat) begin
              cont      <= nb_valid;
              terminate <= ~nb_valid;
              pivot_col <= nb_col;
              pivot_val <= nb_val;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_find_pivot_col_multi.sv
module tb_find_pivot_col_multi;
  localparam int LANES = 4;
  localparam int COLW  = 16;

  logic                clk;
  logic                resetn;
  logic                start;
  logic [COLW-1:0]     num_cols;
  logic                mode;
  logic [31:0]         eps;
  logic [32*LANES-1:0] s_axis_tdata;
  logic                s_axis_tvalid;
  logic                s_axis_tready;
  logic                busy;
  logic                done;
  logic                terminate;
  logic                cont;
  logic [COLW-1:0]     pivot_col;
  logic [31:0]         pivot_val;

  find_pivot_col_multi #(.LANES(LANES), .COLW(COLW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .num_cols(num_cols),
    .mode(mode), .eps(eps), .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .busy(busy), .done(done), .terminate(terminate), .cont(cont),
    .pivot_col(pivot_col), .pivot_val(pivot_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          tag;
    logic        term;
    logic        cnt;
    logic [15:0] col;
    logic [31:0] val;
    int unsigned dcyc;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (done) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending result", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check($sformatf("t%0d_done_cycle", e.tag), cyc, e.dcyc);
        check($sformatf("t%0d_terminate", e.tag), {31'b0, terminate}, {31'b0, e.term});
        check($sformatf("t%0d_cont", e.tag), {31'b0, cont}, {31'b0, e.cnt});
        check($sformatf("t%0d_pivot_col", e.tag), {16'b0, pivot_col}, {16'b0, e.col});
        check($sformatf("t%0d_pivot_val", e.tag), pivot_val, e.val);
      end
    end
  end

  task automatic expect_res(input int tag, input logic t, input logic c,
                            input logic [15:0] col, input logic [31:0] val,
                            input int unsigned dc);
    exp_t e;
    e.tag = tag; e.term = t; e.cnt = c; e.col = col; e.val = val; e.dcyc = dc;
    sbq.push_back(e);
  endtask

  task automatic do_start(input logic [15:0] n, input logic m, input logic [31:0] e);
    num_cols = n; mode = m; eps = e; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns the cycle number of the edge that accepted the beat.
  task automatic send_beat(input logic [127:0] d, input int gap, output int unsigned acc);
    bit ok;
    ok = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (s_axis_tready) begin
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    acc = cyc;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = {4{32'hC2C80000}};
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL beat_accept_timeout: got tready=0 for 50 cycles expected acceptance");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  localparam logic [127:0] B_A0 = {32'hFF800000, 32'h80000000, 32'hC1200000, 32'h40800000};
  localparam logic [127:0] B_A1 = {32'hC2C80000, 32'hC2C80000, 32'hC2C80000, 32'hC0000000};
  localparam logic [127:0] B_C0 = {32'hBF800000, 32'hFFC00000, 32'h00000000, 32'hBF000000};
  localparam logic [127:0] B_T0 = {32'hC0000000, 32'hC0400000, 32'hBF800000, 32'h3F800000};
  localparam logic [127:0] B_T1 = {32'h40A00000, 32'hC0400000, 32'hBF800000, 32'h00000000};
  localparam logic [127:0] B_E0 = {32'hC2C80000, 32'hBF000000, 32'hBF800000, 32'hBFC00000};

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by time limit expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a;
    resetn = 1'b0; start = 1'b0; num_cols = '0; mode = 1'b0; eps = '0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0;
    idle(3);
    check("reset_outputs", {25'b0, s_axis_tready, busy, done, terminate, cont, |pivot_col, |pivot_val}, 32'h0);
    resetn = 1'b1;
    idle(2);

    // Dantzig: -INF wins, masked -100.0 lanes ignored
    do_start(16'd5, 1'b0, 32'h0);
    check("busy_in_scan", {31'b0, busy}, 32'h1);
    send_beat(B_A0, 0, a);
    send_beat(B_A1, 0, a);
    expect_res(1, 1'b0, 1'b1, 16'd3, 32'hFF800000, a);
    idle(3);

    // Bland: first negative (-10.0 at column 1), both beats drained
    do_start(16'd5, 1'b1, 32'h0);
    send_beat(B_A0, 0, a);
    send_beat(B_A1, 0, a);
    expect_res(2, 1'b0, 1'b1, 16'd1, 32'hC1200000, a);
    idle(3);

    // eps = 1.0, no qualifier (-1.0 equals eps, NaN rejected)
    do_start(16'd4, 1'b0, 32'h3F800000);
    send_beat(B_C0, 0, a);
    expect_res(3, 1'b1, 1'b0, 16'd0, 32'h0, a);
    idle(2);

    // Dantzig tie across beats with 3-cycle gaps: earlier column kept
    do_start(16'd8, 1'b0, 32'h0);
    send_beat(B_T0, 3, a);
    send_beat(B_T1, 3, a);
    expect_res(4, 1'b0, 1'b1, 16'd2, 32'hC0400000, a);
    idle(2);

    // Bland on the same row, locked after the first beat
    do_start(16'd8, 1'b1, 32'h0);
    send_beat(B_T0, 0, a);
    send_beat(B_T1, 2, a);
    expect_res(5, 1'b0, 1'b1, 16'd1, 32'hBF800000, a);
    idle(2);

    // Start while busy is ignored; eps boundary and masking in one beat
    do_start(16'd3, 1'b0, 32'h3F800000);
    do_start(16'd0, 1'b1, 32'h0);
    send_beat(B_E0, 0, a);
    expect_res(6, 1'b0, 1'b1, 16'd0, 32'hBFC00000, a);
    idle(2);

    // num_cols = 0: done the cycle after start, no tready
    do_start(16'd0, 1'b0, 32'h0);
    expect_res(7, 1'b1, 1'b0, 16'd0, 32'h0, cyc);
    check("zero_cols_tready_report", {31'b0, s_axis_tready}, 32'h0);
    idle(1);
    check("zero_cols_tready_idle", {31'b0, s_axis_tready}, 32'h0);
    idle(2);

    // Reset mid-scan: everything clears, no done
    do_start(16'd8, 1'b0, 32'h0);
    send_beat(B_T0, 0, a);
    resetn = 1'b0;
    #1;
    check("midscan_reset_outputs", {25'b0, s_axis_tready, busy, done, terminate, cont, |pivot_col, |pivot_val}, 32'h0);
    idle(3);
    resetn = 1'b1;
    idle(1);

    // Fresh scan after reset
    do_start(16'd5, 1'b0, 32'h0);
    send_beat(B_A0, 0, a);
    send_beat(B_A1, 1, a);
    expect_res(8, 1'b0, 1'b1, 16'd3, 32'hFF800000, a);
    idle(5);

    check("scoreboard_drained", sbq.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
